// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: 16-bit sequential ALU controller with a valid/ready request side
// and a valid/ready result side. ADD/SUB saturate and XOR completes in one cycle.
// SLL/SRA/ROR shift one bit per cycle. The flags {N,V,Z} are updated only on
// the edge that enters DONE.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   opcode[3:0]          0 ADD, 1 SUB, 2 XOR, 4 SLL, 5 SRA, 6 ROR, others unsupported
//   a_in[15:0]           operand A / shift source
//   b_in[15:0]           operand B; b_in[3:0] is the shift amount
//   res_valid/res_ready  result handshake (valid only in DONE)
//   res_out[15:0]        registered result
//   flag_out[2:0]        registered flags {N,V,Z}
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  opcode,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_out,
    output logic [2:0]  flag_out
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FLAG_W = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_XOR = 4'h2;
    localparam logic [OP_W-1:0] OP_SLL = 4'h4;
    localparam logic [OP_W-1:0] OP_SRA = 4'h5;
    localparam logic [OP_W-1:0] OP_ROR = 4'h6;

    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [FLAG_W-1:0]   flag_q, flag_d;
    logic                req_ready_q, req_ready_d;
    logic                res_valid_q, res_valid_d;

    // One-bit shift step for the latched shift opcode.
    function automatic logic [DATA_W-1:0] shift1(input logic [OP_W-1:0] op,
                                                 input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        case (op)
            OP_SLL:  r = {v[DATA_W-2:0], 1'b0};
            OP_SRA:  r = {v[DATA_W-1], v[DATA_W-1:1]};
            default: r = {v[0], v[DATA_W-1:1]};
        endcase
        return r;
    endfunction

    // Sign-extended 17-bit sums: bit 16 is the true sign, so bit16 != bit15 means overflow.
    logic [DATA_W:0]   add_w, sub_w;
    logic              add_ovf, sub_ovf;
    logic [DATA_W-1:0] add_sat, sub_sat, xor_res, sh_next;

    always_comb begin
        add_w   = {a_in[DATA_W-1], a_in} + {b_in[DATA_W-1], b_in};
        sub_w   = {a_in[DATA_W-1], a_in} - {b_in[DATA_W-1], b_in};
        add_ovf = add_w[DATA_W] ^ add_w[DATA_W-1];
        sub_ovf = sub_w[DATA_W] ^ sub_w[DATA_W-1];
        add_sat = add_ovf ? (add_w[DATA_W] ? SAT_NEG : SAT_POS) : add_w[DATA_W-1:0];
        sub_sat = sub_ovf ? (sub_w[DATA_W] ? SAT_NEG : SAT_POS) : sub_w[DATA_W-1:0];
        xor_res = a_in ^ b_in;
        sh_next = shift1(op_q, sh_q);
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flag_d  = flag_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = opcode;
                    state_d = S_DONE;
                    case (opcode)
                        OP_ADD: begin
                            res_d  = add_sat;
                            flag_d = {add_sat[DATA_W-1], add_ovf, add_sat == '0};
                        end
                        OP_SUB: begin
                            res_d  = sub_sat;
                            flag_d = {sub_sat[DATA_W-1], sub_ovf, sub_sat == '0};
                        end
                        OP_XOR: begin
                            res_d     = xor_res;
                            flag_d[0] = (xor_res == '0);
                        end
                        OP_SLL, OP_SRA, OP_ROR: begin
                            sh_d  = a_in;
                            cnt_d = b_in[CNT_W-1:0];
                            if (b_in[CNT_W-1:0] == '0) begin
                                res_d     = a_in;
                                flag_d[0] = (a_in == '0);
                            end else begin
                                state_d = S_SHIFT;
                            end
                        end
                        default: begin
                            res_d = '0;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - CNT_W'(1);
                // Result and Z are committed only on the final step.
                if (cnt_q == CNT_W'(1)) begin
                    res_d     = sh_next;
                    flag_d[0] = (sh_next == '0);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        res_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            flag_q      <= '0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            flag_q      <= flag_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign res_valid = res_valid_q;
    assign res_out   = res_q;
    assign flag_out  = flag_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl: scenario tasks with a result scoreboard and an
// integer-arithmetic reference model.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  opcode;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_out;
    logic [2:0]  flag_out;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  fl;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [2:0]  mflags;
    int          checks;
    int          failures;

    alu_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .opcode    (opcode),
        .a_in      (a_in),
        .b_in      (b_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out   (res_out),
        .flag_out  (flag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: signed integer math with explicit clamping, loop-based shifts.
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output int lat);
        int   s;
        logic v;
        lat = 1;
        case (op)
            4'h0, 4'h1: begin
                if (op == 4'h0) s = int'($signed(a)) + int'($signed(b));
                else            s = int'($signed(a)) - int'($signed(b));
                v = 1'b0;
                if (s > 32767)       begin s = 32767;  v = 1'b1; end
                else if (s < -32768) begin s = -32768; v = 1'b1; end
                r = 16'(s);
                mflags = {r[15], v, (r == 16'h0000)};
            end
            4'h2: begin
                r = a ^ b;
                mflags[0] = (r == 16'h0000);
            end
            4'h4, 4'h5, 4'h6: begin
                r = a;
                for (int i = 0; i < int'(b[3:0]); i++) begin
                    if (op == 4'h4)      r = {r[14:0], 1'b0};
                    else if (op == 4'h5) r = {r[15], r[15:1]};
                    else                 r = {r[0], r[15:1]};
                end
                lat = 1 + int'(b[3:0]);
                mflags[0] = (r == 16'h0000);
            end
            default: r = 16'h0000;
        endcase
    endtask

    // Issue one request, scramble inputs after accept, then check result, flags, latency.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   w;
        int   lat;
        @(negedge clk);
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_wait op=%h got=%b want=1", op, req_ready);
        end
        model(op, a, b, e.res, e.lat);
        e.fl = mflags;
        sb.push_back(e);
        req_valid = 1'b1; opcode = op; a_in = a; b_in = b;
        @(posedge clk); #1;
        req_valid = 1'b0; a_in = ~a; b_in = 16'($urandom); opcode = 4'h0;
        lat = 1;
        while (res_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        checks += 3;
        if (res_out !== e.res) begin
            failures++;
            $display("FAIL result op=%h a=%h b=%h got=%h want=%h", op, a, b, res_out, e.res);
        end
        if (flag_out !== e.fl) begin
            failures++;
            $display("FAIL flags op=%h a=%h b=%h got=%b want=%b", op, a, b, flag_out, e.fl);
        end
        if (lat !== e.lat || res_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency op=%h got=%0d want=%0d valid=%b", op, lat, e.lat, res_valid);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL drain op=%h got valid=%b ready=%b want 0/1", op, res_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
        opcode = 4'h0; a_in = 16'h0; b_in = 16'h0;
        mflags = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (res_out !== 16'h0000) begin failures++; $display("FAIL reset_res got=%h want=0000", res_out); end
        if (flag_out !== 3'b000)  begin failures++; $display("FAIL reset_flags got=%b want=000", flag_out); end
        if (res_valid !== 1'b0)   begin failures++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
        if (req_ready !== 1'b1)   begin failures++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        run_op(4'h0, 16'h7FFF, 16'h0001);
        run_op(4'h1, 16'h8000, 16'h0001);
        run_op(4'h2, 16'h5A5A, 16'h5A5A);
        checks++;
        if (flag_out !== 3'b111) begin failures++; $display("FAIL xor_flag_hold got=%b want=111", flag_out); end
        run_op(4'h0, 16'h1234, 16'h0001);
        run_op(4'h1, 16'h7FFF, 16'hFFFF);
        run_op(4'h0, 16'hFFFF, 16'h0001);
        run_op(4'h0, 16'h8000, 16'h8000);
    endtask

    task automatic test_shift();
        run_op(4'h4, 16'h0001, 16'h0004);
        run_op(4'h6, 16'h0001, 16'h0001);
        run_op(4'h5, 16'h8000, 16'h000F);
        run_op(4'h4, 16'hABCD, 16'h0000);
        run_op(4'h5, 16'h4000, 16'h0003);
        run_op(4'h6, 16'h0003, 16'hFFF2);
        run_op(4'h4, 16'h8000, 16'h0001);
    endtask

    task automatic test_unsupported();
        run_op(4'h0, 16'h8000, 16'h0001);
        run_op(4'h2, 16'h1234, 16'h1234);
        run_op(4'hF, 16'hFFFF, 16'h0001);
        checks += 2;
        if (flag_out !== 3'b101) begin failures++; $display("FAIL unsup_flags got=%b want=101", flag_out); end
        if (res_out !== 16'h0000) begin failures++; $display("FAIL unsup_res got=%h want=0000", res_out); end
        run_op(4'h3, 16'h1111, 16'h2222);
    endtask

    task automatic test_backpressure();
        exp_t e;
        @(negedge clk);
        model(4'h0, 16'h1111, 16'h2222, e.res, e.lat);
        e.fl = mflags;
        sb.push_back(e);
        req_valid = 1'b1; opcode = 4'h0; a_in = 16'h1111; b_in = 16'h2222;
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (res_valid !== 1'b1 || res_out !== e.res || flag_out !== e.fl) begin
            failures++;
            $display("FAIL bp_first got v=%b r=%h f=%b want 1/%h/%b", res_valid, res_out, flag_out, e.res, e.fl);
        end
        for (int i = 0; i < 3; i++) begin
            a_in = 16'($urandom);
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_out !== e.res || flag_out !== e.fl) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b r=%h f=%b want 1/0/%h/%b",
                         i, res_valid, req_ready, res_out, flag_out, e.res, e.fl);
            end
        end
        opcode = 4'h2; a_in = 16'h00FF; b_in = 16'h0F0F;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got v=%b rdy=%b want 0/1", res_valid, req_ready);
        end
        model(4'h2, 16'h00FF, 16'h0F0F, e.res, e.lat);
        e.fl = mflags;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (res_valid !== 1'b1 || res_out !== e.res || flag_out !== e.fl) begin
            failures++;
            $display("FAIL bp_next got v=%b r=%h f=%b want 1/%h/%b", res_valid, res_out, flag_out, e.res, e.fl);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; opcode = 4'h4; a_in = 16'h0001; b_in = 16'h0008;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        mflags = 3'b000;
        #1;
        checks++;
        if (res_out !== 16'h0000 || flag_out !== 3'b000 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid got r=%h f=%b v=%b rdy=%b want 0000/000/0/1", res_out, flag_out, res_valid, req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_pulse cyc=%0d got=%b want=0", i, res_valid);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model(4'h0, 16'h0005, 16'h0003, e.res, e.lat);
        e.fl = mflags;
        sb.push_back(e);
        req_valid = 1'b1; opcode = 4'h0; a_in = 16'h0005; b_in = 16'h0003;
        @(posedge clk); #1;
        req_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (res_valid !== 1'b1 || res_out !== e.res || flag_out !== e.fl) begin
            failures++;
            $display("FAIL rst_first_accept got v=%b r=%h f=%b want 1/%h/%b", res_valid, res_out, flag_out, e.res, e.fl);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [7];
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h4;
        ops[4] = 4'h5; ops[5] = 4'h6; ops[6] = 4'h9;
        for (int i = 0; i < 24; i++) begin
            run_op(ops[$urandom_range(0, 6)], 16'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_arith();
        test_shift();
        test_unsupported();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits and the flag vector at 3 bits {N,V,Z}.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 opcode  input  4  0000 ADD, 0001 SUB, 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR; all others unsupported.
REQ-007 a_in  input  16  operand A, or shift source.
REQ-008 b_in  input  16  operand B; for shifts only b_in[3:0] is the shift amount.
REQ-009 res_valid  output  1  result and flags valid; high only in DONE.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_out  output  16  registered result.
REQ-012 flag_out  output  3  registered flag register: [2]=N, [1]=V, [0]=Z.

Function
REQ-013 The FSM SHALL have three states (IDLE, SHIFT, DONE); transfers occur only when both valid and ready are high on a rising edge.
REQ-014 IDLE, on accepting ADD/SUB/XOR/unsupported: compute the result, register it into res_out, and go to DONE, so res_valid rises 1 cycle after the accept edge.
REQ-015 IDLE, on accepting SLL/SRA/ROR: load a_in into the shift register and b_in[3:0] into a 4-bit count; go to DONE if the count is 0, else go to SHIFT.
REQ-016 SHIFT SHALL apply a one-bit shift each cycle and decrement the count, then enter DONE on the edge where the count reaches 0, so res_valid rises count+1 cycles after the accept edge.
REQ-017 Shift semantics: SLL fills 0 at bit 0; SRA replicates bit 15; ROR moves bit 0 into bit 15.
REQ-018 ADD/SUB SHALL be 16-bit two's-complement saturating.
  - Positive overflow yields 0x7FFF.
  - Negative overflow yields 0x8000.
  - SUB computes a_in - b_in.
REQ-019 XOR SHALL produce a_in ^ b_in.
REQ-020 Z SHALL be 1 exactly when the final res_out is 0x0000; it is not the OR-reduction of the result.
REQ-021 N SHALL equal bit 15 of the saturated result, and V SHALL be 1 when saturation occurred, else 0.
REQ-022 Flag update mask:
  - ADD/SUB update N, V and Z.
  - XOR, SLL, SRA and ROR update Z only; N and V hold.
  - Unsupported opcodes update no flags and yield res_out = 0x0000.
REQ-023 Flags SHALL be written on the same edge that enters DONE, never earlier, so intermediate shift values never affect the flags.
REQ-024 DONE SHALL hold res_out and flag_out stable while res_ready is low, and return to IDLE on the edge where res_ready is high.
REQ-025 req_ready SHALL be low in SHIFT and DONE.
  - A req_valid asserted in those states is not accepted.
  - A simultaneous res_ready handshake in DONE does not accept a new request in that cycle; the earliest next accept is the following cycle in IDLE.
REQ-026 Operands and opcode SHALL be captured at the accept edge, and input changes after acceptance SHALL not affect the in-flight operation.

Reset
REQ-027 While rst_n is low: state = IDLE, res_out = 0x0000, flag_out = 3'b000, count = 0, shift register = 0, res_valid = 0, req_ready = 1.
REQ-028 Assertion of rst_n in any state, including mid-SHIFT or mid-DONE, SHALL take effect immediately and discard the in-flight operation.
REQ-029 After rst_n deasserts, the first request SHALL be acceptable on the first rising edge.

Verification
REQ-030 ADD a=0x7FFF b=0x0001 -> res_valid 1 cycle after accept, res_out=0x7FFF, flag_out=3'b010.
REQ-031 SUB a=0x8000 b=0x0001 -> res_out=0x8000, flag_out=3'b110; then XOR a=0x5A5A b=0x5A5A -> res_out=0x0000, flag_out=3'b111 (N,V held, Z set).
REQ-032 SLL a=0x0001 b=0x0004 -> four SHIFT cycles, res_valid 5 cycles after accept, res_out=0x0010; ROR a=0x0001 b=0x0001 -> 0x8000; SRA a=0x8000 b=0x000F -> 0xFFFF; shift by 0 -> latency 1, res_out=a_in.
REQ-033 Backpressure: hold res_ready=0 for 3 cycles in DONE with req_valid=1 and changing a_in -> res_out and flag_out stable, req_ready=0, no accept; release -> IDLE, then next request accepted.
REQ-034 Assert rst_n=0 during the SHIFT of SLL by 8 -> outputs go to REQ-027 values immediately, with no res_valid pulse for the aborted operation.
REQ-035 Unsupported opcode 0xF after a flag state of 3'b101 -> res_out=0x0000, flag_out remains 3'b101, res_valid 1 cycle after accept.
